// File: rtl/data_memory_if.sv
// Request/response bus between the MEM-stage pipeline (master) and the data memory (slave).
interface data_memory_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned ADDR_SIZE = 32
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_write;
    logic [1:0]             req_size;
    logic                   req_unsigned;
    logic [ADDR_SIZE-1:0]   req_addr;
    logic [4*WIDTH-1:0]     req_wdata;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [4*WIDTH-1:0]     rsp_rdata;
    logic                   rsp_error;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_memory.sv
// Big-endian byte-addressed data memory with valid/ready handshake, configurable read latency,
// signed/unsigned sub-word loads and flagging of illegal, misaligned or out-of-range accesses.
module data_memory #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SIZE      = 3000,
    parameter int unsigned ADDR_SIZE = 32,
    parameter int unsigned LATENCY   = 1
) (
    input logic          clk,
    input logic          rst_n,
    data_memory_if.slave bus
);
    localparam int unsigned DW = 4 * WIDTH;
    localparam int unsigned IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned CW = 4;
    localparam int unsigned EW = ADDR_SIZE + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam state_t FIRST = (LATENCY > 1) ? WAIT : RESP;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [WIDTH-1:0] mem [SIZE];

    logic             accept;
    logic             size_err;
    logic             align_err;
    logic             range_err;
    logic             req_err;
    logic             wr_en;
    logic [2:0]       nbytes;
    logic [EW-1:0]    end_addr;
    logic [IW-1:0]    idx0;
    logic [IW-1:0]    idx1;
    logic [IW-1:0]    idx2;
    logic [IW-1:0]    idx3;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] b1;
    logic [WIDTH-1:0] b2;
    logic [WIDTH-1:0] b3;
    logic [DW-1:0]    load_data;
    logic [DW-1:0]    rdata_nxt;

    logic             rsp_valid_q;
    logic             rsp_error_q;
    logic [DW-1:0]    rsp_rdata_q;

    // Ready may retire the current response and take a new request in the same cycle.
    assign bus.req_ready = (state == IDLE) || ((state == RESP) && bus.rsp_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_error = rsp_error_q;

    // Range check uses one extra address bit so addresses near the top cannot wrap.
    always_comb begin
        case (bus.req_size)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
        size_err  = (bus.req_size == 2'b11);
        align_err = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
        end_addr  = {1'b0, bus.req_addr} + EW'(nbytes);
        range_err = (end_addr > EW'(SIZE));
        req_err   = size_err || align_err || range_err;
        wr_en     = accept && bus.req_write && !req_err;
    end

    assign idx0 = bus.req_addr[IW-1:0];
    assign idx1 = idx0 + IW'(1);
    assign idx2 = idx0 + IW'(2);
    assign idx3 = idx0 + IW'(3);

    // Lowest address holds the most significant byte.
    always_comb begin
        b0 = mem[idx0];
        b1 = mem[idx1];
        b2 = mem[idx2];
        b3 = mem[idx3];
        case (bus.req_size)
            2'b00:   load_data = bus.req_unsigned ? DW'(b0)
                                                  : {{(3*WIDTH){b0[WIDTH-1]}}, b0};
            2'b01:   load_data = bus.req_unsigned ? DW'({b0, b1})
                                                  : {{(2*WIDTH){b0[WIDTH-1]}}, b0, b1};
            default: load_data = {b0, b1, b2, b3};
        endcase
        rdata_nxt = (req_err || bus.req_write) ? '0 : load_data;
    end

    // Storage is not reset; a store commits at its accept edge.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            case (bus.req_size)
                2'b00: mem[idx0] <= bus.req_wdata[WIDTH-1:0];
                2'b01: begin
                    mem[idx0] <= bus.req_wdata[2*WIDTH-1:WIDTH];
                    mem[idx1] <= bus.req_wdata[WIDTH-1:0];
                end
                default: begin
                    mem[idx0] <= bus.req_wdata[4*WIDTH-1:3*WIDTH];
                    mem[idx1] <= bus.req_wdata[3*WIDTH-1:2*WIDTH];
                    mem[idx2] <= bus.req_wdata[2*WIDTH-1:WIDTH];
                    mem[idx3] <= bus.req_wdata[WIDTH-1:0];
                end
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = FIRST;
                    cnt_nxt   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt <= CW'(1)) begin
                    state_nxt = RESP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    if (accept) begin
                        state_nxt = FIRST;
                        cnt_nxt   = CW'(LATENCY - 1);
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            rsp_valid_q <= (state_nxt == RESP);
            if (accept) begin
                rsp_rdata_q <= rdata_nxt;
                rsp_error_q <= req_err;
            end
        end
    end
endmodule
